// File: rtl/k_warb_t1_if.sv
// Write-port bundle between the requesters/FIFO write control and the arbiter.
// The arbiter consumes the slave view; the requester side uses master.
interface k_warb_t1_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] din;
  logic                      wfull;
  logic [NUM_REQ-1:0]        ack;
  logic                      wput;
  logic [DATA_W-1:0]         wdata;
  logic [2:0]                owner;
  logic                      busy;

  modport master (
    output req, din, wfull,
    input  ack, wput, wdata, owner, busy
  );

  modport slave (
    input  req, din, wfull,
    output ack, wput, wdata, owner, busy
  );
endinterface

// File: rtl/k_warb_t1.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bursts of up to MAX_BURST words, throttled by the registered full flag.
module k_warb_t1 #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         wclk_i,
  input  logic         wrst_n_i,
  k_warb_t1_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic [3:0] LAST_BEAT  = 4'(MAX_BURST - 1);
  localparam logic [2:0] LAST_RESET = 3'(NUM_REQ - 1);

  logic [0:0] state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q,  last_d;
  logic [3:0] cnt_q,   cnt_d;

  logic              busy;
  logic              own_req;
  logic [DATA_W-1:0] own_data;
  logic              wput;
  logic              hi_found, lo_found;
  logic [2:0]        hi_idx, lo_idx;
  logic              any_req;
  logic [2:0]        winner;
  logic              release_now;

  assign busy = (state_q == ST_OWN);

  // Lowest requester above last wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = 3'd0;
    lo_idx   = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (3'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = 3'(i);
        end
      end
    end
    any_req = hi_found | lo_found;
    winner  = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    own_req  = 1'b0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = bus.req[i];
        own_data = bus.din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wput = busy & own_req & ~bus.wfull;

  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.ack[i] = wput & (owner_q == 3'(i));
    end
  end

  assign bus.wput  = wput;
  assign bus.wdata = busy ? own_data : '0;
  assign bus.owner = busy ? owner_q : 3'd0;
  assign bus.busy  = busy;

  // Release always lands in IDLE, so the next grant is one bubble cycle later.
  assign release_now = ~own_req | (wput & (cnt_q == LAST_BEAT));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (any_req) begin
        state_d = ST_OWN;
        owner_d = winner;
        cnt_d   = 4'd0;
      end
    end else begin
      if (release_now) begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        cnt_d   = 4'd0;
      end else if (wput) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= 3'd0;
      last_q  <= LAST_RESET;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_k_warb_t1.sv
// Directed, table-driven bench for the round-robin FIFO write-port arbiter.
module tb_k_warb_t1;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic        wfull;
    logic        wput;
    logic [3:0]  ack;
    logic [7:0]  wdata;
    logic [2:0]  owner;
    logic        busy;
  } vec_t;

  logic wclk;
  logic wrst_n;
  int   checks;
  int   failures;
  vec_t tbl[$];

  k_warb_t1_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  k_warb_t1 #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .wclk_i   (wclk),
    .wrst_n_i (wrst_n),
    .bus      (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic vec_t mk(logic [3:0] req, logic [31:0] din, logic wfull,
                              logic wput, logic [3:0] ack, logic [7:0] wdata,
                              logic [2:0] owner, logic busy);
    vec_t v;
    v.req = req; v.din = din; v.wfull = wfull;
    v.wput = wput; v.ack = ack; v.wdata = wdata; v.owner = owner; v.busy = busy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    cmp({tag, ".wput"},  32'(bus.wput),  32'(v.wput));
    cmp({tag, ".ack"},   32'(bus.ack),   32'(v.ack));
    cmp({tag, ".wdata"}, 32'(bus.wdata), 32'(v.wdata));
    cmp({tag, ".owner"}, 32'(bus.owner), 32'(v.owner));
    cmp({tag, ".busy"},  32'(bus.busy),  32'(v.busy));
  endtask

  // Called at posedge+1: drive, settle, compare, advance one cycle.
  task automatic run_vec(input string tag, input vec_t v);
    bus.req   = v.req;
    bus.din   = v.din;
    bus.wfull = v.wfull;
    #2;
    check_outs(tag, v);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    int   order [4];
    logic [7:0] wd [4];
    logic [3:0] ak [4];
    checks   = 0;
    failures = 0;
    order = '{3, 0, 1, 3};
    wd    = '{8'hD3, 8'hD0, 8'hD1, 8'hD3};
    ak    = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};

    // Single requester 2, six words across two bursts.
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 0, 0, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(mk(4'b0100, 32'h00A0_0000, 0, 0, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(mk(4'b0100, 32'h00A0_0000, 0, 1, 4'b0100, 8'hA0, 2, 1));
    tbl.push_back(mk(4'b0100, 32'h00A1_0000, 0, 1, 4'b0100, 8'hA1, 2, 1));
    tbl.push_back(mk(4'b0100, 32'h00A2_0000, 0, 1, 4'b0100, 8'hA2, 2, 1));
    tbl.push_back(mk(4'b0100, 32'h00A3_0000, 0, 1, 4'b0100, 8'hA3, 2, 1));
    tbl.push_back(mk(4'b0100, 32'h00A4_0000, 0, 0, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(mk(4'b0100, 32'h00A4_0000, 0, 1, 4'b0100, 8'hA4, 2, 1));
    tbl.push_back(mk(4'b0100, 32'h00A5_0000, 0, 1, 4'b0100, 8'hA5, 2, 1));
    tbl.push_back(mk(4'b0000, 32'h00A5_0000, 0, 0, 4'b0000, 8'hA5, 2, 1));
    tbl.push_back(mk(4'b0000, 32'h00A5_0000, 0, 0, 4'b0000, 8'h00, 0, 0));
    // Requesters 0,1,3 held; last is 2 here, so order is 3,0,1,3.
    for (int g = 0; g < 4; g++) begin
      tbl.push_back(mk(4'b1011, 32'hD300_D1D0, 0, 0, 4'b0000, 8'h00, 0, 0));
      for (int b = 0; b < 4; b++)
        tbl.push_back(mk(4'b1011, 32'hD300_D1D0, 0, 1, ak[g], wd[g], 3'(order[g]), 1));
    end
    tbl.push_back(mk(4'b0000, 32'hD300_D1D0, 0, 0, 4'b0000, 8'h00, 0, 0));

    bus.req = 4'b1111; bus.din = 32'hFFFF_FFFF; bus.wfull = 1'b0;
    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    check_outs("reset", mk(4'b1111, 32'hFFFF_FFFF, 0, 0, 4'b0000, 8'h00, 0, 0));
    bus.req = 4'b0000;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Backpressure: owner 1 at cnt=2 sees wfull for five cycles.
    run_vec("bp0", mk(4'b0010, 32'h0000_B000, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("bp1", mk(4'b0010, 32'h0000_B000, 0, 1, 4'b0010, 8'hB0, 1, 1));
    run_vec("bp2", mk(4'b0010, 32'h0000_B100, 0, 1, 4'b0010, 8'hB1, 1, 1));
    for (int i = 0; i < 5; i++)
      run_vec($sformatf("bpfull%0d", i), mk(4'b0010, 32'h0000_B200, 1, 0, 4'b0000, 8'hB2, 1, 1));
    run_vec("bp8",  mk(4'b0010, 32'h0000_B200, 0, 1, 4'b0010, 8'hB2, 1, 1));
    run_vec("bp9",  mk(4'b0010, 32'h0000_B300, 0, 1, 4'b0010, 8'hB3, 1, 1));
    run_vec("bp10", mk(4'b0000, 32'h0000_B300, 0, 0, 4'b0000, 8'h00, 0, 0));

    // Early release: owner 0 drops after one word, requester 1 waiting.
    run_vec("er0", mk(4'b0011, 32'h0000_E1E0, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("er1", mk(4'b0011, 32'h0000_E1E0, 0, 1, 4'b0001, 8'hE0, 0, 1));
    run_vec("er2", mk(4'b0010, 32'h0000_E1E0, 0, 0, 4'b0000, 8'hE0, 0, 1));
    run_vec("er3", mk(4'b0010, 32'h0000_E1E0, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("er4", mk(4'b0010, 32'h0000_E1E0, 0, 1, 4'b0010, 8'hE1, 1, 1));
    run_vec("er5", mk(4'b0000, 32'h0000_E1E0, 0, 0, 4'b0000, 8'hE1, 1, 1));
    run_vec("er6", mk(4'b0000, 32'h0000_E1E0, 0, 0, 4'b0000, 8'h00, 0, 0));

    // Owner 3 drops req while full; next grant wraps to 0.
    run_vec("df0", mk(4'b1000, 32'hF300_00C0, 1, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("df1", mk(4'b1001, 32'hF300_00C0, 1, 0, 4'b0000, 8'hF3, 3, 1));
    run_vec("df2", mk(4'b0001, 32'hF300_00C0, 1, 0, 4'b0000, 8'hF3, 3, 1));
    run_vec("df3", mk(4'b0001, 32'hF300_00C0, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("df4", mk(4'b0001, 32'hF300_00C0, 0, 1, 4'b0001, 8'hC0, 0, 1));
    run_vec("df5", mk(4'b0000, 32'hF300_00C0, 0, 0, 4'b0000, 8'hC0, 0, 1));
    run_vec("df6", mk(4'b0000, 32'hF300_00C0, 0, 0, 4'b0000, 8'h00, 0, 0));

    // Async reset mid-burst with owner 2 at cnt=1.
    run_vec("ar0", mk(4'b0100, 32'h0092_0090, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("ar1", mk(4'b0100, 32'h0092_0090, 0, 1, 4'b0100, 8'h92, 2, 1));
    bus.req = 4'b0101;
    #2;
    check_outs("ar2", mk(4'b0101, 32'h0092_0090, 0, 1, 4'b0100, 8'h92, 2, 1));
    wrst_n = 1'b0;
    #1;
    check_outs("ar_async", mk(4'b0101, 32'h0092_0090, 0, 0, 4'b0000, 8'h00, 0, 0));
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    run_vec("ar3", mk(4'b0101, 32'h0092_0090, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("ar4", mk(4'b0101, 32'h0092_0090, 0, 1, 4'b0001, 8'h90, 0, 1));
    run_vec("ar5", mk(4'b0100, 32'h0092_0090, 0, 0, 4'b0000, 8'h90, 0, 1));
    run_vec("ar6", mk(4'b0100, 32'h0092_0090, 0, 0, 4'b0000, 8'h00, 0, 0));
    run_vec("ar7", mk(4'b0100, 32'h0092_0090, 0, 1, 4'b0100, 8'h92, 2, 1));
    run_vec("ar8", mk(4'b0000, 32'h0092_0090, 0, 0, 4'b0000, 8'h92, 2, 1));
    run_vec("ar9", mk(4'b0000, 32'h0092_0090, 0, 0, 4'b0000, 8'h00, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/k_warb_t1.md
# k_warb_t1

Round-robin write-port arbiter for the asynchronous FIFO write domain. It shares the single FIFO write port (`wput`/`waddr` pointer logic plus `wfull` flag) among `num_req` requesters on `wclk`. A granted requester keeps the port for a burst of up to `max_burst` words. All pushes are throttled by `wfull`, so no write is ever issued into a full FIFO.

## Interface
- `num_req`, default 4: number of requesters, 2..8.
- `data_size`, default 8: FIFO word width.
- `max_burst`, default 4: maximum words per grant, 1..15.
- `wclk`  in  1: write-domain clock; all state on rising edge.
- `wrst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  `num_req`: per-requester write request; held with data until acked.
- `din`  in  `num_req*data_size`: requester i's word on bits [i*data_size +: data_size].
- `wfull`  in  1: FIFO full flag from the write-control block.
- `ack`  out  `num_req`: one-hot word-accepted strobe; word pushed this cycle.
- `wput`  out  1: FIFO write strobe, to write-control `wput` and memory write enable.
- `wdata`  out  `data_size`: word to FIFO memory.
- `owner`  out  3: index of current grant holder (0 when idle).
- `busy`  out  1: a grant is held (state OWN).

## Operation
- State machine, states IDLE and OWN. Registers: `state`, `owner`, `last` (last released owner), burst counter `cnt` (4 bits).
- IDLE: if any `req` bit is set, pick the first set bit searching from `last`+1 upward, modulo `num_req`. On the next edge: state=OWN, owner=winner, cnt=0. If no `req` bit is set, stay in IDLE.
- OWN: `wput` = `req[owner]` & !`wfull` (combinational). `ack[owner]` = `wput`, and all other `ack` bits are 0. `wdata` = owner's `din` slice. These are combinational from registered owner/state.
- In OWN, on each edge with `wput`=1: cnt increments.
- Release to IDLE on the edge where either (`wput` & cnt==`max_burst`-1) or !`req[owner]`. On release, `last`<=owner and cnt<=0.
- `wfull` with `req[owner]` held: grant is kept indefinitely. There is no timeout and cnt does not advance.
- Owner drops `req` while `wfull`: release normally, with no write.
- `req` of non-owners is ignored until the next IDLE cycle. They see no `ack`.
- IDLE: `wput`=0, `ack`=0, `wdata`=0.
- Release and re-arbitration are not merged: exactly one IDLE cycle sits between grants (arbitration bubble).

## Timing
- Reset (async assert, sync-released by parent): state=IDLE, owner=0, cnt=0, `last`=`num_req`-1, so requester 0 has top priority first.
- Reset output values: `wput`=0, `ack`=0, `wdata`=0, `owner`=0, `busy`=0.
- Latency: `req` rising in IDLE at cycle N gives grant registered at N+1. First `wput`/`ack` comes in cycle N+1 if `wfull`=0.
- Burst throughput: one word per cycle while `req` is held and `wfull`=0.
- A burst of `max_burst` words occupies `max_burst` OWN cycles plus 1 IDLE cycle.
- `wfull` rises in the same cycle as an intended push: `wput`=0 that cycle, and the word stays pending at the requester.
- `wfull` is the registered flag from the full logic. It already accounts for the push of the previous cycle, so the arbiter adds no lookahead.
- Reset mid-burst: returns to IDLE immediately. The partially sent burst is not resumed; the requester re-requests.
- Requester contract: `din` slice stable and `req` held from assertion until `ack` is seen. `req` may drop only after an `ack` cycle, or while no grant is held.

## Test plan
- Single requester: `num_req`=4, `max_burst`=4, req[2] held for 6 words 0xA0..0xA5, `wfull`=0. Expected: owner=2 at N+1; `wput` and `ack[2]` pulse for A0..A3; one IDLE cycle; regrant to 2; A4, A5 written; FIFO receives 6 words in order.
- Round-robin fairness: req[0], req[1], req[3] all held continuously. Expected grant order 0,1,3,0,1,3…; each grant gives exactly 4 acks; never two consecutive grants to the same index while others wait.
- Backpressure: owner 1 mid-burst with cnt=2, force `wfull`=1 for 5 cycles. Expected: `wput`=0 and `ack`=0 throughout; `busy`=1 and owner=1 held; after `wfull` falls, remaining 2 words written, then release.
- Early release: owner 0 drops `req` after 1 word with `max_burst`=4, req[1] pending. Expected: release at that edge, one IDLE cycle, then owner=1; `last`=0.
- Drop while full: owner 3 with `wfull`=1 drops `req`. Expected: release without any `wput`; next grant goes to the lowest set index after 3 (wrap to 0).
- Async reset mid-burst: assert `wrst_n`=0 between edges during owner=2 cnt=1. Expected: `wput`, `ack`, `busy` go to 0 immediately without a clock; after release, req[0] and req[2] both pending give grant to 0 first.
